// File: rtl/multicycle_control_v2.sv
// multicycle_control_v2: multicycle CPU control FSM (fetch/decode/exec/mem/wb) with dmem wait-state timeout, HALT, program load and illegal-opcode detection
// Ports: clk, reset (async, active-low); in: program_mode, prog_valid, opcode, result_lsb, dmem_ready;
//   out: fetch/PC enables, ALU enables/select, dmem enables, reg write + source select, halted, illegal_op, mem_error.
// Define CTRL_PERF_CNT_EN to add instr_count, a 16-bit retired-instruction counter.
module multicycle_control_v2 #(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                program_mode,
  input  logic                prog_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                result_lsb,
  input  logic                dmem_ready,
  output logic                ir_enable,
  output logic                imem_read,
  output logic                imem_write,
  output logic                pc_increment,
  output logic                pc_enable,
  output logic                pc_clear,
  output logic                alu_reg_enable,
  output logic                alu_src_B,
  output logic                alu_out_reg_enable,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                dmem_out_reg_enable,
  output logic                reg_write_enable,
  output logic [1:0]          select_reg_write_data,
  output logic                halted,
  output logic                illegal_op,
`ifdef CTRL_PERF_CNT_EN
  output logic [15:0]         instr_count,
`endif
  output logic                mem_error
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT, PROG} state_t;
  localparam logic [OPCODE_W-1:0] OP_NOP   = '0;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BRZ   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(6);
  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                err_q, err_d;
  logic                illegal, timeout;
  assign illegal = opcode > OP_HALT;
  // Fires on the cycle whose increment would reach MEM_TIMEOUT; a ready in that cycle wins.
  assign timeout = MEM_TIMEOUT != 0 && !dmem_ready && to_q == TO_W'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_q  <= '0;
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      to_q  <= to_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    op_d    = state_q == DECODE ? opcode : op_q;
    to_d    = '0;
    err_d   = err_q;
    unique case (state_q)
      FETCH:  state_d = program_mode ? PROG : DECODE;
      DECODE: state_d = opcode == OP_HALT ? HALT : (opcode == OP_NOP || illegal) ? FETCH : EXEC;
      EXEC:   state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : op_q == OP_BRZ ? BRANCH : WB;
      MEM: begin
        to_d    = (dmem_ready || timeout) ? '0 : to_q + 1'b1;
        err_d   = err_q | timeout;
        state_d = dmem_ready ? (op_q == OP_LOAD ? WB : FETCH) : timeout ? HALT : MEM;
      end
      WB, BRANCH: state_d = FETCH;
      HALT:   state_d = program_mode ? PROG : HALT;
      PROG: begin
        err_d   = err_q & program_mode;
        state_d = program_mode ? PROG : FETCH;
      end
    endcase
  end
  // Every output is qualified by reset so the block is silent while reset is held.
  always_comb begin
    ir_enable             = reset && state_q == FETCH;
    imem_read             = reset && state_q == FETCH;
    imem_write            = reset && state_q == PROG && prog_valid;
    pc_increment          = reset && (state_q == FETCH || (state_q == PROG && prog_valid));
    pc_enable             = reset && state_q == BRANCH && !result_lsb;
    pc_clear              = reset && state_q == PROG && !program_mode;
    alu_reg_enable        = reset && state_q == DECODE;
    alu_src_B             = reset && state_q == EXEC && (op_q == OP_ADDI || op_q == OP_LOAD || op_q == OP_STORE);
    alu_out_reg_enable    = reset && state_q == EXEC;
    dmem_read             = reset && state_q == MEM && op_q == OP_LOAD;
    dmem_write            = reset && state_q == MEM && op_q == OP_STORE;
    dmem_out_reg_enable   = reset && state_q == MEM && op_q == OP_LOAD && dmem_ready;
    reg_write_enable      = reset && state_q == WB;
    select_reg_write_data = (reset && state_q == WB && op_q == OP_LOAD) ? 2'd1 : 2'd0;
    halted                = reset && state_q == HALT;
    illegal_op            = reset && state_q == DECODE && illegal;
  end
  assign mem_error = err_q;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] cnt_q;
  logic        retire;
  // A timeout (MEM -> HALT) does not retire; only returns to FETCH count.
  assign retire = state_d == FETCH && (state_q == DECODE || state_q == WB || state_q == BRANCH || state_q == MEM);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else if (state_q == PROG && !program_mode) cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 16'd1;
  assign instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_multicycle_control_v2.sv
// tb_multicycle_control_v2: self-checking bench for multicycle_control_v2 (directed table, corner sequences, random instruction stream)
module tb_multicycle_control_v2;
  localparam logic [17:0] F    = 18'h34000;
  localparam logic [17:0] IMW  = 18'h08000;
  localparam logic [17:0] PCI  = 18'h04000;
  localparam logic [17:0] PCE  = 18'h02000;
  localparam logic [17:0] PCC  = 18'h01000;
  localparam logic [17:0] ARE  = 18'h00800;
  localparam logic [17:0] ASB  = 18'h00400;
  localparam logic [17:0] AOE  = 18'h00200;
  localparam logic [17:0] DR   = 18'h00100;
  localparam logic [17:0] DW   = 18'h00080;
  localparam logic [17:0] DOE  = 18'h00040;
  localparam logic [17:0] RWE  = 18'h00020;
  localparam logic [17:0] SEL1 = 18'h00008;
  localparam logic [17:0] HLT  = 18'h00004;
  localparam logic [17:0] ILL  = 18'h00002;
  localparam logic [17:0] ERR  = 18'h00001;
  logic clk, reset, program_mode, prog_valid, result_lsb, dmem_ready;
  logic [3:0] opcode;
  logic ir_enable, imem_read, imem_write, pc_increment, pc_enable, pc_clear;
  logic alu_reg_enable, alu_src_B, alu_out_reg_enable;
  logic dmem_read, dmem_write, dmem_out_reg_enable, reg_write_enable;
  logic [1:0] select_reg_write_data;
  logic halted, illegal_op, mem_error;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] instr_count;
`endif
  multicycle_control_v2 #(.OPCODE_W(4), .MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .program_mode(program_mode), .prog_valid(prog_valid),
    .opcode(opcode), .result_lsb(result_lsb), .dmem_ready(dmem_ready),
    .ir_enable(ir_enable), .imem_read(imem_read), .imem_write(imem_write),
    .pc_increment(pc_increment), .pc_enable(pc_enable), .pc_clear(pc_clear),
    .alu_reg_enable(alu_reg_enable), .alu_src_B(alu_src_B), .alu_out_reg_enable(alu_out_reg_enable),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_out_reg_enable(dmem_out_reg_enable),
    .reg_write_enable(reg_write_enable), .select_reg_write_data(select_reg_write_data),
    .halted(halted), .illegal_op(illegal_op),
`ifdef CTRL_PERF_CNT_EN
    .instr_count(instr_count),
`endif
    .mem_error(mem_error)
  );
  typedef struct {
    logic [3:0]  op;
    bit          lsb, rdy, pm, pv;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0, retired = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [17:0] outs();
    return {ir_enable, imem_read, imem_write, pc_increment, pc_enable, pc_clear, alu_reg_enable,
            alu_src_B, alu_out_reg_enable, dmem_read, dmem_write, dmem_out_reg_enable,
            reg_write_enable, select_reg_write_data, halted, illegal_op, mem_error};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask
  task automatic p(input int op, input bit lsb, input bit rdy, input bit pm, input bit pv, input logic [17:0] e);
    vec_t v;
    v.op = 4'(op); v.lsb = lsb; v.rdy = rdy; v.pm = pm; v.pv = pv; v.exp = e;
    tbl.push_back(v);
  endtask
  task automatic apply(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      opcode = tbl[i].op; result_lsb = tbl[i].lsb; dmem_ready = tbl[i].rdy;
      program_mode = tbl[i].pm; prog_valid = tbl[i].pv;
      #1 chk($sformatf("%s[%0d]", nm, i), 32'(outs()), 32'(tbl[i].exp));
    end
    tbl.delete();
  endtask
  // Reference model: expands one instruction into its per-cycle output expectations.
  task automatic add_instr(input int op, input bit lsb, input int w);
    p(op, lsb, 0, 0, 0, F);
    p(op, lsb, 0, 0, 0, op > 6 ? ARE | ILL : ARE);
    retired++;
    if (op == 0 || op > 6) return;
    p(op, lsb, 0, 0, 0, op inside {2, 3, 4} ? AOE | ASB : AOE);
    if (op == 5) p(op, lsb, 0, 0, 0, lsb ? 18'h0 : PCE);
    if (op == 3 || op == 4) begin
      for (int i = 0; i < w; i++) p(op, lsb, 0, 0, 0, op == 3 ? DR : DW);
      p(op, lsb, 1, 0, 0, op == 3 ? DR | DOE : DW);
    end
    if (op inside {1, 2, 3}) p(op, lsb, 0, 0, 0, op == 3 ? RWE | SEL1 : RWE);
  endtask
  task automatic timeout_store();
    p(4, 0, 0, 0, 0, F);
    p(4, 0, 0, 0, 0, ARE);
    p(4, 0, 0, 0, 0, AOE | ASB);
    for (int i = 0; i < 16; i++) p(4, 0, 0, 0, 0, DW);
    p(4, 0, 0, 0, 0, HLT | ERR);
  endtask
  initial begin
    reset = 0; program_mode = 0; prog_valid = 0; opcode = 0; result_lsb = 0; dmem_ready = 0;
    p(1, 0, 0, 0, 0, F); p(1, 0, 0, 0, 0, ARE); p(1, 0, 0, 0, 0, AOE); p(1, 0, 0, 0, 0, RWE);
    p(2, 0, 0, 0, 0, F); p(2, 0, 0, 0, 0, ARE); p(2, 0, 0, 0, 0, AOE | ASB); p(2, 0, 0, 0, 0, RWE);
    p(5, 0, 0, 0, 0, F); p(5, 0, 0, 0, 0, ARE); p(5, 0, 0, 0, 0, AOE); p(5, 0, 0, 0, 0, PCE);
    p(5, 1, 0, 0, 0, F); p(5, 1, 0, 0, 0, ARE); p(5, 1, 0, 0, 0, AOE); p(5, 1, 0, 0, 0, 18'h0);
    p(3, 0, 0, 0, 0, F); p(3, 0, 0, 0, 0, ARE); p(3, 0, 0, 0, 0, AOE | ASB);
    p(3, 0, 0, 0, 0, DR); p(3, 0, 0, 0, 0, DR); p(3, 0, 0, 0, 0, DR);
    p(3, 0, 1, 0, 0, DR | DOE); p(3, 0, 0, 0, 0, RWE | SEL1);
    p(4, 0, 0, 0, 0, F); p(4, 0, 0, 0, 0, ARE); p(4, 0, 0, 0, 0, AOE | ASB);
    p(4, 0, 0, 0, 0, DW); p(4, 0, 1, 0, 0, DW);
    p(4, 0, 0, 0, 0, F); p(4, 0, 0, 0, 0, ARE); p(4, 0, 0, 0, 0, AOE | ASB); p(4, 0, 1, 0, 0, DW);
    p(0, 0, 0, 0, 0, F); p(0, 0, 0, 0, 0, ARE);
    p(9, 0, 0, 0, 0, F); p(9, 0, 0, 0, 0, ARE | ILL);
    p(15, 0, 0, 0, 0, F); p(15, 0, 0, 0, 0, ARE | ILL);
    p(7, 0, 0, 0, 0, F); p(7, 0, 0, 0, 0, ARE | ILL);
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", 32'(outs()), 32'h0);
    @(posedge clk);
    #2 reset = 1;
    apply("directed");
    timeout_store();
    p(4, 0, 0, 0, 0, HLT | ERR);
    p(4, 0, 0, 1, 0, HLT | ERR);
    p(0, 0, 0, 1, 1, IMW | PCI | ERR); p(0, 0, 0, 1, 0, ERR);
    p(0, 0, 0, 1, 1, IMW | PCI | ERR); p(0, 0, 0, 1, 0, ERR);
    p(0, 0, 0, 1, 1, IMW | PCI | ERR);
    p(0, 0, 0, 0, 0, PCC | ERR);
    apply("timeout_prog");
    @(posedge clk);
    #1 chk("err_cleared_on_prog_exit", 32'(mem_error), 32'h0);
`ifdef CTRL_PERF_CNT_EN
    chk("count_after_prog", 32'(instr_count), 32'h0);
`endif
    add_instr(0, 0, 0);
    p(6, 0, 0, 0, 0, F); p(6, 0, 0, 0, 0, ARE); p(6, 0, 0, 0, 0, HLT);
    p(6, 0, 0, 1, 0, HLT); p(0, 0, 0, 0, 0, PCC);
    p(1, 0, 0, 0, 0, F); p(1, 0, 0, 1, 0, ARE); p(1, 0, 0, 1, 0, AOE); p(1, 0, 0, 1, 0, RWE);
    p(0, 0, 0, 1, 0, F); p(0, 0, 0, 0, 1, PCC | IMW | PCI);
    apply("halt_prog");
    retired = 0;
    for (int i = 0; i < 80; i++) begin
      int op;
      op = int'($urandom_range(0, 14));
      if (op >= 6) op++;
      add_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    apply("random");
    @(posedge clk);
`ifdef CTRL_PERF_CNT_EN
    #1 chk("instr_count", 32'(instr_count), 32'(retired));
`endif
    timeout_store();
    apply("timeout2");
    #1 reset = 0;
    #1 chk("async_reset_outputs", 32'(outs()), 32'h0);
    @(posedge clk);
    #2 reset = 1;
    add_instr(1, 0, 0);
    apply("after_reset");
    $display("retired %0d", retired);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
